reg_file_wb_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two writeback sources.
  - ALU/immediate results: single-cycle, stallable.
  - Memory load returns: fixed-latency, non-stallable.
- Deferred ALU writes are held in a small in-order queue and drained when the port is free.
- Drives the write enable, address, data and the 2-bit wdata source select consumed by the register-file write-data mux.
- Sits between execute/memory stage outputs and the register file.

---
 rtl/reg_file_wb_arbiter_pkg.sv | 30 +++
 rtl/reg_file_wb_arbiter_wb_fifo.sv | 85 ++++++++
 rtl/reg_file_wb_arbiter.sv | 156 +++++++++++++++
 tb/tb_reg_file_wb_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   - rf_wdata_sel encodings consumed by the register-file write-data mux
//   - default data/address widths and queue occupancy counter width
//   - queue entry layout {imm, rd, data}
package reg_file_wb_arbiter_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned CNT_W      = 3;

    localparam logic [SEL_W-1:0] WSEL_MEM  = 2'b00;
    localparam logic [SEL_W-1:0] WSEL_MEMB = 2'b01;
    localparam logic [SEL_W-1:0] WSEL_IMM  = 2'b10;
    localparam logic [SEL_W-1:0] WSEL_ALU  = 2'b11;

    // Queue entry at default widths; the top packs the same {imm, rd, data}
    // layout into a flat vector so non-default widths work too.
    typedef struct packed {
        logic                  imm;
        logic [DEF_ADDR_W-1:0] rd;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int unsigned entry_width(input int unsigned addr_w,
                                                input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/reg_file_wb_arbiter_wb_fifo.sv
// Circular in-order queue holding deferred ALU writebacks.
// Ports:
//   clock_i, reset_i : clock, synchronous active-low reset (flushes pointers/count)
//   push_i, wdata_i  : enqueue at tail (ignored when full)
//   pop_i            : dequeue head (ignored when empty)
//   head_o           : oldest entry
//   count_o          : occupancy 0..DEPTH
//   full_o, empty_o  : occupancy flags
module reg_file_wb_arbiter_wb_fifo
    import reg_file_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 38
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clock_i) begin
        if (do_push && reset_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Register-file write-port arbiter between load returns (non-stallable,
// highest priority) and ALU/immediate results (stallable, queued when the
// port is busy or older ALU results are still waiting).
// Ports:
//   clock_i, reset_i           : clock, synchronous active-low reset
//   alu_valid_i/imm_i/rd_i/data_i, alu_ready_o : ALU writeback handshake
//   mem_valid_i/byte_i/rd_i/data_i             : load return (always accepted)
//   rf_we_o, rf_waddr_o, rf_wdata_o, rf_wdata_sel_o : registered write port
//   q_count_o                  : deferred-queue occupancy
//   deferred_cnt_o             : saturating count of deferred ALU writes,
//                                present only when WB_ARB_STATS_EN is defined
module reg_file_wb_arbiter
    import reg_file_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              alu_valid_i,
    input  logic              alu_imm_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mem_valid_i,
    input  logic              mem_byte_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [SEL_W-1:0]  rf_wdata_sel_o,
    output logic [CNT_W-1:0]  q_count_o
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]       deferred_cnt_o
`endif
);

    localparam int unsigned ENTRY_W = entry_width(ADDR_W, DATA_W);

    logic [ENTRY_W-1:0] alu_entry, q_head;
    logic [CNT_W-1:0]   q_count;
    logic               q_full, q_empty;
    logic               alu_acc, push, pop, grant;
    logic [ADDR_W-1:0]  g_rd;
    logic [DATA_W-1:0]  g_data;
    logic [SEL_W-1:0]   g_sel;

    logic               rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
    logic [SEL_W-1:0]   rf_wdata_sel_q, rf_wdata_sel_d;

    assign alu_ready_o = reset_i && !q_full;
    assign alu_entry   = {alu_imm_i, alu_rd_i, alu_data_i};

    reg_file_wb_arbiter_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (alu_entry),
        .head_o  (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // Grant: load return, then oldest queued ALU write, then ALU bypass.
    // Any accepted ALU write that loses the port goes to the queue tail.
    always_comb begin
        alu_acc = alu_valid_i && alu_ready_o;
        grant   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        g_rd    = '0;
        g_data  = '0;
        g_sel   = WSEL_MEM;
        if (mem_valid_i) begin
            grant  = 1'b1;
            push   = alu_acc;
            g_rd   = mem_rd_i;
            g_data = mem_byte_i ? {{(DATA_W-8){mem_data_i[7]}}, mem_data_i[7:0]}
                                : mem_data_i;
            g_sel  = mem_byte_i ? WSEL_MEMB : WSEL_MEM;
        end else if (!q_empty) begin
            grant  = 1'b1;
            pop    = 1'b1;
            push   = alu_acc;
            g_rd   = q_head[DATA_W +: ADDR_W];
            g_data = q_head[DATA_W-1:0];
            g_sel  = q_head[ENTRY_W-1] ? WSEL_IMM : WSEL_ALU;
        end else if (alu_acc) begin
            grant  = 1'b1;
            g_rd   = alu_rd_i;
            g_data = alu_data_i;
            g_sel  = alu_imm_i ? WSEL_IMM : WSEL_ALU;
        end
    end

    // r0 writes still consume their slot and update address/data/select.
    always_comb begin
        rf_we_d        = grant && (g_rd != '0);
        rf_waddr_d     = grant ? g_rd   : rf_waddr_q;
        rf_wdata_d     = grant ? g_data : rf_wdata_q;
        rf_wdata_sel_d = grant ? g_sel  : rf_wdata_sel_q;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            rf_wdata_sel_q <= WSEL_MEM;
        end else begin
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            rf_wdata_sel_q <= rf_wdata_sel_d;
        end
    end

    assign rf_we_o        = rf_we_q;
    assign rf_waddr_o     = rf_waddr_q;
    assign rf_wdata_o     = rf_wdata_q;
    assign rf_wdata_sel_o = rf_wdata_sel_q;
    assign q_count_o      = q_count;

`ifdef WB_ARB_STATS_EN
    logic [15:0] deferred_q, deferred_d;

    // Saturating count of ALU writes that had to wait in the queue.
    always_comb begin
        deferred_d = deferred_q;
        if (push && (deferred_q != 16'hFFFF)) begin
            deferred_d = deferred_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            deferred_q <= '0;
        end else begin
            deferred_q <= deferred_d;
        end
    end

    assign deferred_cnt_o = deferred_q;
`endif

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Self-checking bench for reg_file_wb_arbiter: directed vector table with
// hand-derived expectations, then randomized traffic against a queue model.
module tb_reg_file_wb_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset_i = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic        alu_imm_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        alu_ready_o;
    logic        mem_valid_i = 1'b0;
    logic        mem_byte_i = 1'b0;
    logic [4:0]  mem_rd_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [1:0]  rf_wdata_sel_o;
    logic [2:0]  q_count_o;
`ifdef WB_ARB_STATS_EN
    logic [15:0] deferred_cnt_o;
`endif

    always #5 clock = ~clock;

    reg_file_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clock_i        (clock),
        .reset_i        (reset_i),
        .alu_valid_i    (alu_valid_i),
        .alu_imm_i      (alu_imm_i),
        .alu_rd_i       (alu_rd_i),
        .alu_data_i     (alu_data_i),
        .alu_ready_o    (alu_ready_o),
        .mem_valid_i    (mem_valid_i),
        .mem_byte_i     (mem_byte_i),
        .mem_rd_i       (mem_rd_i),
        .mem_data_i     (mem_data_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .rf_wdata_sel_o (rf_wdata_sel_o),
        .q_count_o      (q_count_o)
`ifdef WB_ARB_STATS_EN
        ,
        .deferred_cnt_o (deferred_cnt_o)
`endif
    );

    typedef struct packed {
        logic        imm;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct packed {
        logic        rst;
        logic        av;
        logic        imm;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        mv;
        logic        mb;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        e_ready;
        logic        e_we;
        logic        e_dchk;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [1:0]  e_sel;
        logic [2:0]  e_q;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;

    // Reference model state: pending ALU writes in arrival order.
    ent_t        mq[$];
    logic        m_we, m_dchk, m_acc;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [1:0]  m_sel;
    logic [15:0] m_defer = '0;
    logic        last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock of inputs, check alu_ready before the edge and the
    // registered outputs just after it against the model.
    task automatic cycle(input logic rst, input logic av, input logic aimm,
                         input logic [4:0] ard, input logic [31:0] adata,
                         input logic mv, input logic mb,
                         input logic [4:0] mrd, input logic [31:0] mdata);
        ent_t e;
        logic exp_ready, granted, push;
        reset_i     = rst;
        alu_valid_i = av;
        alu_imm_i   = aimm;
        alu_rd_i    = ard;
        alu_data_i  = adata;
        mem_valid_i = mv;
        mem_byte_i  = mb;
        mem_rd_i    = mrd;
        mem_data_i  = mdata;
        #1;
        exp_ready  = rst && (mq.size() < DEPTH);
        last_ready = alu_ready_o;
        chk("alu_ready", 32'(alu_ready_o), 32'(exp_ready));
        m_acc = av && exp_ready;
        push  = 1'b0;
        if (!rst) begin
            mq.delete();
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_sel = 2'd0;
            m_dchk = 1'b1; m_defer = '0;
        end else begin
            granted = 1'b1;
            if (mv) begin
                m_waddr = mrd;
                m_wdata = mb ? 32'($signed(mdata[7:0])) : mdata;
                m_sel   = mb ? 2'd1 : 2'd0;
                push    = m_acc;
            end else if (mq.size() != 0) begin
                e       = mq.pop_front();
                m_waddr = e.rd;
                m_wdata = e.data;
                m_sel   = e.imm ? 2'd2 : 2'd3;
                push    = m_acc;
            end else if (m_acc) begin
                m_waddr = ard;
                m_wdata = adata;
                m_sel   = aimm ? 2'd2 : 2'd3;
            end else begin
                granted = 1'b0;
            end
            m_dchk = granted;
            m_we   = granted && (m_waddr != 5'd0);
            if (push) begin
                e.imm = aimm; e.rd = ard; e.data = adata;
                mq.push_back(e);
                if (m_defer != 16'hFFFF) m_defer = m_defer + 16'd1;
            end
        end
        @(posedge clock);
        #1;
        chk("rf_we", 32'(rf_we_o), 32'(m_we));
        chk("q_count", 32'(q_count_o), 32'(mq.size()));
        if (m_dchk) begin
            chk("rf_waddr", 32'(rf_waddr_o), 32'(m_waddr));
            chk("rf_wdata", rf_wdata_o, m_wdata);
            chk("rf_wdata_sel", 32'(rf_wdata_sel_o), 32'(m_sel));
        end
`ifdef WB_ARB_STATS_EN
        chk("deferred_cnt", 32'(deferred_cnt_o), 32'(m_defer));
`endif
    endtask

    vec_t tbl[18];

    initial begin
        logic        hold, p_av, p_imm, mv, mb;
        logic [4:0]  p_rd, mrd;
        logic [31:0] p_data, mdata;
        logic        rst;

        // {rst,av,imm,ard,adata, mv,mb,mrd,mdata, e_ready,e_we,e_dchk, e_waddr,e_wdata,e_sel,e_q}
        tbl[0]  = '{1'b0,1'b0,1'b0,5'd0,32'h0,     1'b0,1'b0,5'd0,32'h0,   1'b0,1'b0,1'b1, 5'd0,32'h0,2'd0,3'd0};
        tbl[1]  = '{1'b1,1'b1,1'b0,5'd3,32'h1234,  1'b0,1'b0,5'd0,32'h0,   1'b1,1'b1,1'b1, 5'd3,32'h1234,2'd3,3'd0};
        tbl[2]  = '{1'b1,1'b0,1'b0,5'd0,32'h0,     1'b0,1'b0,5'd0,32'h0,   1'b1,1'b0,1'b0, 5'd0,32'h0,2'd0,3'd0};
        tbl[3]  = '{1'b1,1'b1,1'b0,5'd5,32'h7,     1'b1,1'b0,5'd4,32'hAA,  1'b1,1'b1,1'b1, 5'd4,32'hAA,2'd0,3'd1};
        tbl[4]  = '{1'b1,1'b0,1'b0,5'd0,32'h0,     1'b0,1'b0,5'd0,32'h0,   1'b1,1'b1,1'b1, 5'd5,32'h7,2'd3,3'd0};
        tbl[5]  = '{1'b1,1'b0,1'b0,5'd0,32'h0,     1'b1,1'b1,5'd9,32'h80,  1'b1,1'b1,1'b1, 5'd9,32'hFFFFFF80,2'd1,3'd0};
        tbl[6]  = '{1'b1,1'b1,1'b1,5'd0,32'hFFFF,  1'b0,1'b0,5'd0,32'h0,   1'b1,1'b0,1'b1, 5'd0,32'hFFFF,2'd2,3'd0};
        tbl[7]  = '{1'b1,1'b1,1'b0,5'd10,32'h10A,  1'b1,1'b0,5'd1,32'h100, 1'b1,1'b1,1'b1, 5'd1,32'h100,2'd0,3'd1};
        tbl[8]  = '{1'b1,1'b1,1'b1,5'd11,32'h11B,  1'b1,1'b0,5'd2,32'h200, 1'b1,1'b1,1'b1, 5'd2,32'h200,2'd0,3'd2};
        tbl[9]  = '{1'b1,1'b1,1'b0,5'd12,32'h12C,  1'b1,1'b0,5'd3,32'h300, 1'b0,1'b1,1'b1, 5'd3,32'h300,2'd0,3'd2};
        tbl[10] = '{1'b1,1'b1,1'b0,5'd12,32'h12C,  1'b0,1'b0,5'd0,32'h0,   1'b0,1'b1,1'b1, 5'd10,32'h10A,2'd3,3'd1};
        tbl[11] = '{1'b1,1'b1,1'b0,5'd12,32'h12C,  1'b0,1'b0,5'd0,32'h0,   1'b1,1'b1,1'b1, 5'd11,32'h11B,2'd2,3'd1};
        tbl[12] = '{1'b1,1'b0,1'b0,5'd0,32'h0,     1'b0,1'b0,5'd0,32'h0,   1'b1,1'b1,1'b1, 5'd12,32'h12C,2'd3,3'd0};
        tbl[13] = '{1'b1,1'b1,1'b0,5'd7,32'h700,   1'b1,1'b0,5'd6,32'h600, 1'b1,1'b1,1'b1, 5'd6,32'h600,2'd0,3'd1};
        tbl[14] = '{1'b1,1'b1,1'b0,5'd13,32'h1300, 1'b1,1'b0,5'd8,32'h800, 1'b1,1'b1,1'b1, 5'd8,32'h800,2'd0,3'd2};
        tbl[15] = '{1'b0,1'b1,1'b0,5'd14,32'h1400, 1'b0,1'b0,5'd0,32'h0,   1'b0,1'b0,1'b1, 5'd0,32'h0,2'd0,3'd0};
        tbl[16] = '{1'b1,1'b0,1'b0,5'd0,32'h0,     1'b0,1'b0,5'd0,32'h0,   1'b1,1'b0,1'b0, 5'd0,32'h0,2'd0,3'd0};
        tbl[17] = '{1'b1,1'b0,1'b0,5'd0,32'h0,     1'b0,1'b0,5'd0,32'h0,   1'b1,1'b0,1'b0, 5'd0,32'h0,2'd0,3'd0};

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].rst, tbl[i].av, tbl[i].imm, tbl[i].ard, tbl[i].adata,
                  tbl[i].mv, tbl[i].mb, tbl[i].mrd, tbl[i].mdata);
            chk("tbl_ready", 32'(last_ready), 32'(tbl[i].e_ready));
            chk("tbl_we", 32'(rf_we_o), 32'(tbl[i].e_we));
            chk("tbl_q_count", 32'(q_count_o), 32'(tbl[i].e_q));
            if (tbl[i].e_dchk) begin
                chk("tbl_waddr", 32'(rf_waddr_o), 32'(tbl[i].e_waddr));
                chk("tbl_wdata", rf_wdata_o, tbl[i].e_wdata);
                chk("tbl_sel", 32'(rf_wdata_sel_o), 32'(tbl[i].e_sel));
            end
        end

        // Randomized traffic with load bursts; a stalled ALU write is held.
        hold = 1'b0;
        p_av = 1'b0; p_imm = 1'b0; p_rd = '0; p_data = '0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (!hold) begin
                p_av   = ($urandom_range(0, 99) < 60);
                p_imm  = 1'($urandom_range(0, 1));
                p_rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                p_data = $urandom;
            end
            if (((i / 16) % 3) == 0) mv = ($urandom_range(0, 9) < 9);
            else                     mv = ($urandom_range(0, 9) < 2);
            mb    = 1'($urandom_range(0, 1));
            mrd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            mdata = $urandom;
            cycle(rst, p_av, p_imm, p_rd, p_data, mv, mb, mrd, mdata);
            hold = p_av && !m_acc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
